// File: rtl/trap_redirect_controller_pkg.sv
// Shared definitions for the trap/mret redirect sequencer: exception sentinel,
// FSM state encoding, trap kind and flush mask layout.
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

package trap_redirect_controller_pkg;

  localparam logic [3:0] EXC_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef enum logic {
    TRAP = 1'b0,
    MRET = 1'b1
  } kind_e;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
  } flush_t;

endpackage

// File: rtl/trap_redirect_controller_arbiter.sv
// Combinational age-ordered pick among the trap sources visible in one cycle.
module trap_source_arbiter
  import trap_redirect_controller_pkg::*;
(
  input  logic [3:0] i_exception_code_f_d,
  input  logic [3:0] i_exception_code_e_m,
  input  logic       i_ecall_d,
  input  logic       i_mret_d,
  output logic       o_event_valid,
  output kind_e      o_kind,
  output flush_t     o_flush
);

  // Oldest instruction wins: E/M, then D (mret ahead of ecall), then F/D.
  always_comb begin
    o_event_valid = 1'b1;
    o_kind        = TRAP;
    o_flush       = '{f: 1'b1, d: 1'b1, e: 1'b0};
    if (i_exception_code_e_m != EXC_NONE) begin
      o_flush.e = 1'b1;
    end else if (i_mret_d) begin
      o_kind = MRET;
    end else if (i_ecall_d) begin
      o_kind = TRAP;
    end else if (i_exception_code_f_d != EXC_NONE) begin
      o_kind = TRAP;
    end else begin
      o_event_valid = 1'b0;
      o_flush       = '0;
    end
  end

endmodule

// File: rtl/trap_redirect_controller.sv
// Trap/mret sequencer: flushes on a trap event, drains memory, then issues a
// one-cycle PC redirect (and an mret commit pulse for mret).
module trap_redirect_controller
  import trap_redirect_controller_pkg::*;
#(
  parameter  logic [1:0] XLEN = `XLEN_64b,
  localparam int         W    = 1 << (int'(XLEN) + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic [3:0]   i_exception_code_f_d_ff,
  input  logic [3:0]   i_exception_code_e_m_ff,
  input  logic         i_ecall_d,
  input  logic         i_mret_d,
  input  logic [W-1:0] i_mepc,
  input  logic [W-1:0] i_mtvec,
  input  logic         i_mem_busy,
  output logic         o_stall,
  output logic         o_flush_f,
  output logic         o_flush_d,
  output logic         o_flush_e,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_mret_e,
  output logic         o_busy
);

  state_e       r_state;
  kind_e        r_kind;
  logic [W-1:0] r_target;
  logic         r_stall, r_flush_f, r_flush_d, r_flush_e;
  logic         r_redirect_valid, r_mret_e, r_busy;
  logic [W-1:0] r_redirect_pc;

  logic         w_event_valid;
  kind_e        w_kind;
  flush_t       w_flush;
  logic [W-1:0] w_target;
  logic         w_unused_bits;

  trap_source_arbiter u_arbiter (
    .i_exception_code_f_d (i_exception_code_f_d_ff),
    .i_exception_code_e_m (i_exception_code_e_m_ff),
    .i_ecall_d            (i_ecall_d),
    .i_mret_d             (i_mret_d),
    .o_event_valid        (w_event_valid),
    .o_kind               (w_kind),
    .o_flush              (w_flush)
  );

  // Direct-mode vector only: mtvec mode bits and mepc bit 0 are dropped.
  assign w_target      = (w_kind == MRET) ? {i_mepc[W-1:1], 1'b0}
                                          : {i_mtvec[W-1:2], 2'b00};
  assign w_unused_bits = ^{i_mepc[0], i_mtvec[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_kind           <= TRAP;
      r_stall          <= 1'b0;
      r_flush_f        <= 1'b0;
      r_flush_d        <= 1'b0;
      r_flush_e        <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mret_e         <= 1'b0;
      r_busy           <= 1'b0;
    end else if (i_clk_en) begin
      case (r_state)
        IDLE: begin
          r_redirect_valid <= 1'b0;
          r_mret_e         <= 1'b0;
          r_stall          <= w_event_valid;
          r_busy           <= w_event_valid;
          r_flush_f        <= w_flush.f;
          r_flush_d        <= w_flush.d;
          r_flush_e        <= w_flush.e;
          if (w_event_valid) begin
            r_state  <= DRAIN;
            r_kind   <= w_kind;
            r_target <= w_target;
          end
        end
        DRAIN: begin
          r_flush_f <= 1'b0;
          r_flush_d <= 1'b0;
          r_flush_e <= 1'b0;
          if (!i_mem_busy) begin
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
            r_mret_e         <= (r_kind == MRET);
          end
        end
        REDIRECT: begin
          // Anything sampled here is wrong-path and deliberately dropped.
          r_state          <= IDLE;
          r_stall          <= 1'b0;
          r_busy           <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_mret_e         <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_stall          = r_stall;
  assign o_flush_f        = r_flush_f;
  assign o_flush_d        = r_flush_d;
  assign o_flush_e        = r_flush_e;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_mret_e         = r_mret_e;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_trap_redirect_controller.sv
// Bench for trap_redirect_controller: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the sequencer.
module tb_trap_redirect_controller;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst, en, ecall, mret, mem_busy;
  logic [3:0]   fd_code, em_code;
  logic [W-1:0] mepc, mtvec;
  logic         o_stall, o_flush_f, o_flush_d, o_flush_e;
  logic         o_redirect_valid, o_mret_e, o_busy;
  logic [W-1:0] o_redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: one outstanding redirect request at most.
  bit           m_active, m_redirected, m_mret;
  logic [W-1:0] m_target;
  logic         e_stall, e_ff, e_fd, e_fe, e_rv, e_mret, e_busy;
  logic [W-1:0] e_pc;

  trap_redirect_controller dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_clk_en                (en),
    .i_exception_code_f_d_ff (fd_code),
    .i_exception_code_e_m_ff (em_code),
    .i_ecall_d               (ecall),
    .i_mret_d                (mret),
    .i_mepc                  (mepc),
    .i_mtvec                 (mtvec),
    .i_mem_busy              (mem_busy),
    .o_stall                 (o_stall),
    .o_flush_f               (o_flush_f),
    .o_flush_d               (o_flush_d),
    .o_flush_e               (o_flush_e),
    .o_redirect_valid        (o_redirect_valid),
    .o_redirect_pc           (o_redirect_pc),
    .o_mret_e                (o_mret_e),
    .o_busy                  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ev, from_em, is_mret;
    if (rst) begin
      m_active = 0; m_redirected = 0;
      e_stall = 0; e_ff = 0; e_fd = 0; e_fe = 0; e_rv = 0; e_mret = 0; e_busy = 0;
      e_pc = '0;
    end else if (en) begin
      e_ff = 0; e_fd = 0; e_fe = 0; e_rv = 0; e_mret = 0;
      if (!m_active) begin
        ev = 1; from_em = 0; is_mret = 0;
        if (em_code != 4'hF)      from_em = 1;
        else if (mret)            is_mret = 1;
        else if (ecall)           is_mret = 0;
        else if (fd_code != 4'hF) is_mret = 0;
        else                      ev = 0;
        e_stall = ev; e_busy = ev;
        if (ev) begin
          m_active = 1; m_redirected = 0; m_mret = is_mret;
          m_target = is_mret ? (mepc & ~64'd1) : (mtvec & ~64'd3);
          e_ff = 1; e_fd = 1; e_fe = from_em;
        end
      end else if (m_redirected) begin
        m_active = 0; m_redirected = 0; e_stall = 0; e_busy = 0;
      end else if (!mem_busy) begin
        m_redirected = 1; e_rv = 1; e_pc = m_target; e_mret = m_mret;
      end
    end
  endtask

  // One clock: model at the edge, compare shortly after, return at negedge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("stall",   W'(o_stall),          W'(e_stall));
    chk("flush_f", W'(o_flush_f),        W'(e_ff));
    chk("flush_d", W'(o_flush_d),        W'(e_fd));
    chk("flush_e", W'(o_flush_e),        W'(e_fe));
    chk("rv",      W'(o_redirect_valid), W'(e_rv));
    chk("pc",      o_redirect_pc,        e_pc);
    chk("mret_e",  W'(o_mret_e),         W'(e_mret));
    chk("busy",    W'(o_busy),           W'(e_busy));
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; en = 1; ecall = 0; mret = 0; mem_busy = 0;
    fd_code = 4'hF; em_code = 4'hF;
  endtask

  int pulses;

  initial begin
    quiet(); rst = 1; mepc = '0; mtvec = '0;
    @(negedge clk);
    cycle(); cycle();
    chk("reset_busy", W'(o_busy), '0);
    chk("reset_pc", o_redirect_pc, '0);
    quiet(); cycle();

    // E/M trap, memory idle.
    em_code = 4'h2; mtvec = 64'h8000_0103; cycle();
    chk("t1_flush_e", W'(o_flush_e), 64'd1);
    chk("t1_stall", W'(o_stall), 64'd1);
    quiet(); cycle();
    chk("t1_rv", W'(o_redirect_valid), 64'd1);
    chk("t1_pc", o_redirect_pc, 64'h8000_0100);
    chk("t1_mret", W'(o_mret_e), 64'd0);
    cycle();
    chk("t1_stall_off", W'(o_stall), 64'd0);
    cycle();

    // mret.
    mret = 1; mepc = 64'h0000_1235; fd_code = 4'h1; cycle();
    chk("t2_flush_e", W'(o_flush_e), 64'd0);
    quiet(); cycle();
    chk("t2_pc", o_redirect_pc, 64'h0000_1234);
    chk("t2_mret", W'(o_mret_e), 64'd1);
    cycle(); cycle();

    // Three simultaneous sources: E/M wins.
    fd_code = 4'h0; ecall = 1; em_code = 4'h5; mtvec = 64'h4000_0007; mepc = 64'h9999;
    cycle();
    chk("t3_flush_e", W'(o_flush_e), 64'd1);
    quiet(); pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (o_redirect_valid) pulses++;
      if (i == 0) chk("t3_pc", o_redirect_pc, 64'h4000_0004);
    end
    chk("t3_pulses", W'(pulses), 64'd1);

    // ecall with memory busy 4 cycles.
    ecall = 1; mtvec = 64'h0000_2000; cycle();
    quiet(); mem_busy = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_rv_wait", W'(o_redirect_valid), 64'd0);
    chk("t4_stall", W'(o_stall), 64'd1);
    mem_busy = 0; cycle();
    chk("t4_rv", W'(o_redirect_valid), 64'd1);
    cycle(); cycle();

    // Clock enable low for 3 cycles in DRAIN.
    ecall = 1; mtvec = 64'h0000_3000; cycle();
    quiet(); en = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_frozen_flush", W'(o_flush_f), 64'd1);
    chk("t5_rv_wait", W'(o_redirect_valid), 64'd0);
    en = 1; cycle();
    chk("t5_rv", W'(o_redirect_valid), 64'd1);
    cycle(); cycle();

    // Reset pulse in DRAIN aborts the sequence.
    em_code = 4'h7; mtvec = 64'h0000_5000; cycle();
    quiet(); mem_busy = 1; cycle();
    rst = 1; cycle();
    chk("t6_stall", W'(o_stall), 64'd0);
    quiet(); pulses = 0;
    for (int i = 0; i < 4; i++) begin cycle(); if (o_redirect_valid) pulses++; end
    chk("t6_no_redirect", W'(pulses), 64'd0);

    // Later events during DRAIN and at REDIRECT are ignored.
    em_code = 4'h3; mtvec = 64'h0000_A000; cycle();
    quiet(); mem_busy = 1; em_code = 4'h4; mtvec = 64'h0000_B000; cycle();
    mem_busy = 0; ecall = 1; cycle();
    chk("t7_pc", o_redirect_pc, 64'h0000_A000);
    mret = 1; mepc = 64'h0000_C000; cycle();
    chk("t7_idle", W'(o_busy), 64'd0);
    quiet(); cycle();
    chk("t7_still_idle", W'(o_busy), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 9) != 0);
      em_code  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      fd_code  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      ecall    = ($urandom_range(0, 9) == 0);
      mret     = ($urandom_range(0, 9) == 0);
      mem_busy = $urandom_range(0, 1) == 1;
      mepc     = {$urandom, $urandom};
      mtvec    = {$urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_redirect_controller.md
Name: trap_redirect_controller

Overview:
Sequencer downstream of the CSR unit. It consumes the pipeline exception codes, decode-stage ecall/mret and mepc/mtvec, and turns them into pipeline flush, stall and PC-redirect commands.
- Arbitrates simultaneous trap sources by program age.
- Waits for outstanding memory operations to drain.
- Issues a single-cycle redirect to the trap vector or to mepc, and a one-cycle mret commit pulse back to the CSR register file.

Parameters:
XLEN, `XLEN_64b, 2-bit width code; datapath width W = 1<<(XLEN+4).
EXC_NONE, 4'hF, exception-code value meaning "no exception"; defined in the shared package.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_clk_en  input  1  global clock enable; all state holds when low
i_exception_code_f_d_ff  input  4  fetch/decode exception code (EXC_NONE = none)
i_exception_code_e_m_ff  input  4  execute/memory exception code (EXC_NONE = none)
i_ecall_d  input  1  ecall decoded in D
i_mret_d  input  1  mret decoded in D
i_mepc  input  W  current mepc from CSR file
i_mtvec  input  W  current mtvec from CSR file
i_mem_busy  input  1  data-memory transaction outstanding
o_stall  output  1  freeze F/D/E fetch and advance
o_flush_f  output  1  flush F/D register
o_flush_d  output  1  flush D/E register
o_flush_e  output  1  flush E/M register
o_redirect_valid  output  1  one-cycle PC redirect strobe
o_redirect_pc  output  W  redirect target
o_mret_e  output  1  one-cycle mret commit, drives CSR file i_mret_e
o_busy  output  1  sequencer not IDLE

Behaviour:
- FSM states: IDLE, DRAIN, REDIRECT. All outputs are registered.
- Reset: state = IDLE and every output = 0, including o_redirect_pc. Reset asserted mid-sequence aborts it immediately; no redirect or mret pulse is issued.
- i_clk_en low: state, outputs and captured target hold unchanged; reset still takes effect.
- IDLE, event sampled at cycle T, priority oldest first:
  1. e_m code != EXC_NONE → kind TRAP
  2. i_mret_d → kind MRET
  3. i_ecall_d → kind TRAP
  4. f_d code != EXC_NONE → kind TRAP
- On any event, at T+1: state = DRAIN; o_stall = 1; o_busy = 1; o_flush_f/d/e = 1.
  - Flush scope: all three for an e_m source; flush_f and flush_d only for D or F sources.
- Target captured at T:
  - TRAP: {i_mtvec[W-1:2], 2'b00} (direct mode only; mtvec mode bits ignored).
  - MRET: {i_mepc[W-1:1], 1'b0}.
- DRAIN: flushes deassert after their single cycle; o_stall stays 1.
  - Remain in DRAIN while i_mem_busy = 1.
  - First cycle with i_mem_busy = 0 → REDIRECT on the next cycle.
  - Minimum latency T → redirect is 2 cycles.
- REDIRECT, one cycle: o_redirect_valid = 1, o_redirect_pc = target, o_stall = 1. o_mret_e = 1 only for kind MRET. Next state IDLE.
- Leaving REDIRECT: o_stall, o_busy, o_redirect_valid and o_mret_e return to 0. o_redirect_pc holds its last value.
- New events arriving while not IDLE are ignored; the flush discards them.
- An event sampled in the same cycle that REDIRECT→IDLE occurs is also ignored (post-redirect wrong-path).
- mret is never flushed by an F-stage exception that arrives in the same cycle; it wins by priority.

Decomposition:
- Shared package: EXC_NONE; FSM state encodings (IDLE = 2'd0, DRAIN = 2'd1, REDIRECT = 2'd2); trap-kind encoding (TRAP, MRET).
- Sub-module trap_source_arbiter: combinational priority pick producing event_valid, kind and flush mask.
- The top level holds the FSM and the target register.

Test Plan:
- Reset, then e_m code = 4'h2 at T with i_mtvec = 0x8000_0103 and mem idle → T+1: flush_f/d/e = 1, stall = 1. T+2: redirect_valid = 1, pc = 0x8000_0100, mret_e = 0. T+3: all 0.
- i_mret_d with i_mepc = 0x0000_1235 → redirect pc = 0x0000_1234, mret_e = 1 in the same cycle as redirect_valid; flush_e = 0.
- Same cycle: f_d code = 4'h0, i_ecall_d, e_m code = 4'h5 → flush_e = 1 and target = mtvec; exactly one redirect pulse.
- ecall with i_mem_busy high for 4 cycles after T → stall held, redirect_valid asserted on the cycle after busy drops (T+6).
- i_clk_en low for 3 cycles in DRAIN → outputs frozen, redirect delayed by 3 cycles. Separately, i_rst pulse in DRAIN → all outputs 0 next cycle, no redirect.
- Second exception during DRAIN and at REDIRECT cycle → ignored; only one redirect with the first target.
